// File: rtl/mult_div_unit.sv
// mult_div_unit: execute-stage multiply/divide unit. Holds the architectural
// HI/LO registers and runs multi-cycle mult/multu/div/divu operations.
//
// Ports:
//   clk      in   rising-edge clock
//   reset    in   asynchronous, active-high reset
//   start    in   launch the operation selected by mdctr
//   mdctr    in   3'b001 mult, 3'b010 multu, 3'b011 div, 3'b100 divu
//   a, b     in   rs / rt operands; a is also the mthi/mtlo write data
//   hiwrite  in   mthi: HI <= a (IDLE only)
//   lowrite  in   mtlo: LO <= a (IDLE only)
//   flush    in   cancels start/hiwrite/lowrite in the same cycle
//   busy     out  high while an operation is in flight
//   hi, lo   out  HI/LO registers
//
// Multiply is a single product formed at launch and held until the commit
// edge. Divide is a restoring divider on operand magnitudes that retires
// 4 quotient bits per cycle, so 8 of the DIV_CYCLES busy cycles do the work.
// The divider needs DIV_CYCLES >= 9 to finish before the commit edge.
module mult_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  mdctr,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        hiwrite,
  input  logic        lowrite,
  input  logic        flush,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_CYC   = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W     = ($clog2(MAX_CYC + 1) > 4) ? $clog2(MAX_CYC + 1) : 4;
  localparam int DIV_STEPS = 8;
  localparam int DIV_BITS  = 32 / DIV_STEPS;

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;

  // Divider iterates while cnt is above this value: the first DIV_STEPS run cycles.
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV_CYCLES - DIV_STEPS);
  localparam logic [CNT_W-1:0] MULT_LD  = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LD   = CNT_W'(DIV_CYCLES);

  typedef enum logic {IDLE, RUN} state_t;

  // Context captured at launch for the commit edge.
  typedef struct packed {
    logic [2:0] op;
    logic       neg_q;  // quotient needs negation
    logic       neg_r;  // remainder takes the dividend's sign
    logic       dz;     // divisor was zero: commit nothing
  } md_ctx_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  md_ctx_t            ctx;
  logic [63:0]        prod;
  logic [32:0]        rem;
  logic [31:0]        quo;
  logic [31:0]        dvs;

  // ---------------------------------------------------------------- launch
  logic        op_valid, launch, in_div, sgn_mul, sgn_div;
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag;
  logic [63:0] mul_a, mul_b, mul_p;

  assign op_valid = (mdctr == OP_MULT) || (mdctr == OP_MULTU) ||
                    (mdctr == OP_DIV)  || (mdctr == OP_DIVU);
  assign launch   = (state == IDLE) && start && !flush && op_valid;
  assign in_div   = (mdctr == OP_DIV) || (mdctr == OP_DIVU);
  assign sgn_mul  = (mdctr == OP_MULT);
  assign sgn_div  = (mdctr == OP_DIV);

  // Low 64 bits of the product of sign/zero-extended operands equal the
  // exact 64-bit signed or unsigned product.
  assign mul_a = {{32{sgn_mul & a[31]}}, a};
  assign mul_b = {{32{sgn_mul & b[31]}}, b};
  assign mul_p = mul_a * mul_b;

  assign a_neg = sgn_div & a[31];
  assign b_neg = sgn_div & b[31];
  assign a_mag = a_neg ? (~a + 32'd1) : a;
  assign b_mag = b_neg ? (~b + 32'd1) : b;

  // --------------------------------------------------------- divider step
  // Shift one dividend bit into the partial remainder, subtract the divisor
  // when it fits, and shift the resulting quotient bit into quo.
  logic [32:0] rem_n;
  logic [31:0] quo_n;

  always_comb begin
    rem_n = rem;
    quo_n = quo;
    for (int i = 0; i < DIV_BITS; i++) begin
      rem_n = {rem_n[31:0], quo_n[31]};
      quo_n = {quo_n[30:0], 1'b0};
      if (rem_n >= {1'b0, dvs}) begin
        rem_n    = rem_n - {1'b0, dvs};
        quo_n[0] = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------- commit
  logic        ctx_div;
  logic [31:0] q_fix, r_fix;

  assign ctx_div = (ctx.op == OP_DIV) || (ctx.op == OP_DIVU);
  // Signed overflow (0x80000000 / -1) falls out naturally: |q| = 0x80000000,
  // both signs negative so no negation, remainder 0.
  assign q_fix = ctx.neg_q ? (~quo + 32'd1) : quo;
  assign r_fix = ctx.neg_r ? (~rem[31:0] + 32'd1) : rem[31:0];

  // ------------------------------------------------------------------- FSM
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
      ctx   <= '0;
      prod  <= '0;
      rem   <= '0;
      quo   <= '0;
      dvs   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (launch) begin
            state <= RUN;
            busy  <= 1'b1;
            ctx   <= '{op: mdctr, neg_q: a_neg ^ b_neg, neg_r: a_neg, dz: (b == 32'd0)};
            if (in_div) begin
              cnt <= DIV_LD;
              rem <= '0;
              quo <= a_mag;
              dvs <= b_mag;
            end else begin
              cnt  <= MULT_LD;
              prod <= mul_p;
            end
          end else begin
            // start wins over mthi/mtlo, hence the else
            if (hiwrite && !flush) hi <= a;
            if (lowrite && !flush) lo <= a;
          end
        end
        RUN: begin
          if (cnt == CNT_W'(1)) begin
            state <= IDLE;
            busy  <= 1'b0;
            cnt   <= '0;
            if (ctx_div) begin
              if (!ctx.dz) begin
                hi <= r_fix;
                lo <= q_fix;
              end
            end else begin
              hi <= prod[63:32];
              lo <= prod[31:0];
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
            if (ctx_div && (cnt > DIV_LAST)) begin
              rem <= rem_n;
              quo <= quo_n;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: directed test-plan cases with literal expectations,
// then randomized traffic, all compared every cycle against a transaction-
// level model (result computed with plain arithmetic at acceptance, applied
// at the completion cycle).
module tb_mult_div_unit;
  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  mdctr;
  logic [31:0] a, b;
  logic        hiwrite, lowrite, flush;
  logic        busy;
  logic [31:0] hi, lo;

  mult_div_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .start(start), .mdctr(mdctr), .a(a), .b(b),
    .hiwrite(hiwrite), .lowrite(lowrite), .flush(flush),
    .busy(busy), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // model state
  logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
  bit          p_we = 0;
  longint      cyc = 0, done_at = 0;
  bit          chk_en = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Result of an accepted op from the architectural definition.
  task automatic model_result(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y,
                              output bit we, output logic [31:0] rh, output logic [31:0] rl);
    int          sx, sy, q, r;
    longint      sp;
    logic [63:0] up;
    sx = x; sy = y;
    we = 1; rh = '0; rl = '0;
    case (op)
      3'd1: begin sp = longint'(sx) * longint'(sy); {rh, rl} = sp; end
      3'd2: begin up = 64'(x) * 64'(y); {rh, rl} = up; end
      3'd3: begin
        if (y == 0) we = 0;
        else if (x == 32'h80000000 && y == 32'hFFFFFFFF) begin rl = 32'h80000000; rh = 0; end
        else begin q = sx / sy; r = sx % sy; rl = q; rh = r; end
      end
      3'd4: begin
        if (y == 0) we = 0;
        else begin rl = x / y; rh = x % y; end
      end
      default: we = 0;
    endcase
  endtask

  // Advance the model by one clock edge using the inputs presented before it.
  task automatic model_edge();
    bit running;
    running = (cyc < done_at);
    cyc++;
    if (running) begin
      if (cyc == done_at && p_we) begin m_hi = p_hi; m_lo = p_lo; end
    end else if (start && !flush && mdctr >= 3'd1 && mdctr <= 3'd4) begin
      done_at = cyc + ((mdctr >= 3'd3) ? DC : MC);
      model_result(mdctr, a, b, p_we, p_hi, p_lo);
    end else begin
      if (hiwrite && !flush) m_hi = a;
      if (lowrite && !flush) m_lo = a;
    end
  endtask

  always @(negedge clk) begin
    if (chk_en && !reset) begin
      chk("cyc_busy", 32'(busy), 32'(cyc < done_at));
      chk("cyc_hi", hi, m_hi);
      chk("cyc_lo", lo, m_lo);
    end
  end

  task automatic tick();
    @(posedge clk);
    if (!reset) model_edge();
    @(negedge clk);
  endtask

  task automatic set_idle();
    start = 0; mdctr = 0; hiwrite = 0; lowrite = 0; flush = 0;
  endtask

  // Launch an op and wait (bounded) for busy to drop; n = busy cycles seen.
  task automatic run_op(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y,
                        input bit lw, output int n);
    start = 1; mdctr = op; a = x; b = y; lowrite = lw;
    tick();
    set_idle();
    n = 0;
    while (busy === 1'b1 && n < 40) begin n++; tick(); end
  endtask

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h80000000;
      2: return 32'hFFFFFFFF;
      3: return 32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int n;
    set_idle();
    a = 0; b = 0;
    reset = 1;
    repeat (3) @(negedge clk);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_hi", hi, 32'd0);
    chk("reset_lo", lo, 32'd0);
    reset = 0;
    chk_en = 1;

    // mult -2 * 3
    run_op(3'b001, 32'hFFFFFFFE, 32'd3, 0, n);
    chk("mult_busy_cycles", 32'(n), 32'd5);
    chk("mult_hi", hi, 32'hFFFFFFFF);
    chk("mult_lo", lo, 32'hFFFFFFFA);
    chk("model_mult_lo", m_lo, 32'hFFFFFFFA);

    // multu max * max, back-to-back
    run_op(3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, n);
    chk("multu_hi", hi, 32'hFFFFFFFE);
    chk("multu_lo", lo, 32'h00000001);
    chk("model_multu_hi", m_hi, 32'hFFFFFFFE);

    // div -7 / 2
    run_op(3'b011, 32'hFFFFFFF9, 32'd2, 0, n);
    chk("div_busy_cycles", 32'(n), 32'd10);
    chk("div_lo", lo, 32'hFFFFFFFD);
    chk("div_hi", hi, 32'hFFFFFFFF);
    chk("model_div_hi", m_hi, 32'hFFFFFFFF);

    // preload via mthi+mtlo in one cycle, then divu by zero
    hiwrite = 1; lowrite = 1; a = 32'h1234;
    tick();
    hiwrite = 0; a = 32'h5678;
    tick();
    set_idle();
    chk("mthi", hi, 32'h1234);
    chk("mtlo", lo, 32'h5678);
    run_op(3'b100, 32'd99, 32'd0, 0, n);
    chk("divz_busy_cycles", 32'(n), 32'd10);
    chk("divz_hi", hi, 32'h1234);
    chk("divz_lo", lo, 32'h5678);

    // signed overflow
    run_op(3'b011, 32'h80000000, 32'hFFFFFFFF, 0, n);
    chk("ovf_lo", lo, 32'h80000000);
    chk("ovf_hi", hi, 32'h0);

    // start masked by flush
    start = 1; mdctr = 3'b001; a = 32'd7; b = 32'd7; flush = 1;
    tick();
    set_idle();
    chk("flush_busy", 32'(busy), 32'd0);
    chk("flush_lo", lo, 32'h80000000);

    // mthi during RUN is ignored
    start = 1; mdctr = 3'b001; a = 32'd7; b = 32'd9;
    tick();
    set_idle();
    tick();
    hiwrite = 1; a = 32'hDEAD;
    tick();
    hiwrite = 0;
    n = 0;
    while (busy === 1'b1 && n < 40) begin n++; tick(); end
    chk("run_mthi_hi", hi, 32'h0);
    chk("run_mthi_lo", lo, 32'd63);

    // mtlo together with a valid start: start wins
    run_op(3'b001, 32'd5, 32'd6, 1, n);
    chk("start_mtlo_lo", lo, 32'd30);
    chk("start_mtlo_hi", hi, 32'd0);

    // asynchronous reset three cycles into a div
    start = 1; mdctr = 3'b011; a = 32'd100; b = 32'd7;
    tick();
    set_idle();
    repeat (3) tick();
    #2;
    reset = 1;
    m_hi = 0; m_lo = 0; done_at = cyc;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_hi", hi, 32'd0);
    chk("midrst_lo", lo, 32'd0);
    @(negedge clk);
    reset = 0;
    repeat (12) tick();
    run_op(3'b001, 32'd3, 32'd4, 0, n);
    chk("post_rst_busy_cycles", 32'(n), 32'd5);
    chk("post_rst_lo", lo, 32'd12);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      start   = ($urandom_range(0, 2) == 0);
      mdctr   = 3'($urandom_range(0, 7));
      a       = rnd_val();
      b       = rnd_val();
      hiwrite = ($urandom_range(0, 3) == 0);
      lowrite = ($urandom_range(0, 3) == 0);
      flush   = ($urandom_range(0, 7) == 0);
      tick();
    end
    set_idle();
    repeat (12) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
